// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with leading-zero blanking.
// New digits wait in a shadow register and are applied only at frame start, so the display never tears.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] fird,
  input  logic [3:0] secd,
  input  logic [3:0] third,
  input  logic [3:0] foud,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pending,
  output logic       commit
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_THOU = 2'd0,
    S_HUND = 2'd1,
    S_TENS = 2'd2,
    S_ONES = 2'd3
  } slot_t;

  slot_t       slot, slot_nxt;
  logic [CW-1:0] div_cnt;
  logic [15:0] cur, pend, cur_nxt;
  logic        tick, frame_start, do_commit;
  logic [3:0]  digit, an_sel, an_on, an_nxt;
  logic [6:0]  seg_on, seg_nxt;
  logic        lead_zero, blank;

  // Active-low {g..a} pattern; anything above 9 shows a dash
  function automatic logic [6:0] seg_low(input logic [3:0] d);
    case (d)
      4'd0:    seg_low = 7'b1000000;
      4'd1:    seg_low = 7'b1111001;
      4'd2:    seg_low = 7'b0100100;
      4'd3:    seg_low = 7'b0110000;
      4'd4:    seg_low = 7'b0011001;
      4'd5:    seg_low = 7'b0010010;
      4'd6:    seg_low = 7'b0000010;
      4'd7:    seg_low = 7'b1111000;
      4'd8:    seg_low = 7'b0000000;
      4'd9:    seg_low = 7'b0010000;
      default: seg_low = 7'b0111111;
    endcase
  endfunction

  assign tick        = (div_cnt == LAST);
  assign frame_start = tick && (slot == S_ONES);
  assign do_commit   = frame_start && pending;
  assign cur_nxt     = do_commit ? pend : cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot <= S_ONES;
    else        slot <= slot_nxt;
  end

  always_comb begin
    slot_nxt = slot;
    if (tick) begin
      case (slot)
        S_THOU:  slot_nxt = S_HUND;
        S_HUND:  slot_nxt = S_TENS;
        S_TENS:  slot_nxt = S_ONES;
        default: slot_nxt = S_THOU;
      endcase
    end
  end

  // A load in the commit cycle still lands in pend, so pending stays set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= 16'h0000;
      pend    <= 16'h0000;
      pending <= 1'b0;
      commit  <= 1'b0;
    end else begin
      commit <= do_commit;
      if (do_commit) cur <= pend;
      if (load) begin
        pend    <= {fird, secd, third, foud};
        pending <= 1'b1;
      end else if (do_commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    digit     = cur_nxt[3:0];
    an_sel    = 4'b0001;
    lead_zero = 1'b0;
    case (slot_nxt)
      S_THOU: begin
        digit     = cur_nxt[15:12];
        an_sel    = 4'b1000;
        lead_zero = (cur_nxt[15:12] == 4'd0);
      end
      S_HUND: begin
        digit     = cur_nxt[11:8];
        an_sel    = 4'b0100;
        lead_zero = (cur_nxt[15:8] == 8'd0);
      end
      S_TENS: begin
        digit     = cur_nxt[7:4];
        an_sel    = 4'b0010;
        lead_zero = (cur_nxt[15:4] == 12'd0);
      end
      default: begin
        digit     = cur_nxt[3:0];
        an_sel    = 4'b0001;
        lead_zero = 1'b0;
      end
    endcase
    blank   = BLANK_LZ && lead_zero;
    an_nxt  = blank ? 4'b0000 : an_sel;
    seg_nxt = blank ? 7'b0000000 : ~seg_low(digit);
  end

  // Drive is held internally as active-high "lit" and flipped at the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_on  <= 4'b0000;
      seg_on <= 7'b0000000;
    end else if (tick) begin
      an_on  <= an_nxt;
      seg_on <= seg_nxt;
    end
  end

  assign an  = ACTIVE_LOW ? ~an_on  : an_on;
  assign seg = ACTIVE_LOW ? ~seg_on : seg_on;
  assign dp  = ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model predicts every cycle's
// outputs into a queue, and an independent monitor pops and compares after each clock edge.
module tb_seg7_scan_driver;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] fird = 4'd0, secd = 4'd0, third = 4'd0, foud = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, pending, commit;

  seg7_scan_driver #(.REFRESH_DIV(D), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .fird(fird), .secd(secd), .third(third), .foud(foud),
    .an(an), .seg(seg), .dp(dp), .pending(pending), .commit(commit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pending;
    logic       commit;
  } exp_t;

  localparam logic [6:0] SEG_LOW [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  exp_t        expq[$];
  int          pass_count = 0;
  int          check_count = 0;

  // Reference model: edges since reset release, plus the display-level state
  int          k = 0;
  logic [15:0] m_cur = 16'h0, m_pend = 16'h0;
  bit          m_pending = 1'b0, m_commit = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  bit          prev_rst = 1'b0;

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit next_is_frame_start();
    return (k % D == D - 1) && ((((k + 1) / D) % 4) == 1);
  endfunction

  // Predict the state after the coming rising edge
  task automatic model_step(input bit r, input bit ld, input logic [15:0] v);
    bit          is_tick, fs;
    int          nticks, pos;
    logic [15:0] lead;
    if (!r) begin
      k = 0; m_cur = 16'h0; m_pend = 16'h0; m_pending = 1'b0; m_commit = 1'b0;
      m_an = 4'hF; m_seg = 7'h7F;
      return;
    end
    is_tick  = (k % D == D - 1);
    nticks   = (k + 1) / D;
    fs       = is_tick && (nticks % 4 == 1);
    m_commit = fs && m_pending;
    if (m_commit) begin
      m_cur = m_pend;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_pend = v;
      m_pending = 1'b1;
    end
    k++;
    if (is_tick) begin
      pos  = (3 + nticks) % 4;
      lead = m_cur >> (4 * (3 - pos));
      if (pos < 3 && lead == 16'h0) begin
        m_an = 4'hF; m_seg = 7'h7F;
      end else begin
        m_an  = ~(4'b0001 << (3 - pos));
        m_seg = (lead[3:0] > 4'd9) ? 7'b0111111 : SEG_LOW[lead[3:0]];
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ld, input logic [15:0] v);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    load  = ld;
    {fird, secd, third, foud} = v;
    if (!r && prev_rst) begin
      #1;
      checkOutput("async_rst", {3'b0, an, seg}, {3'b0, 4'hF, 7'h7F});
    end
    prev_rst = r;
    model_step(r, ld, v);
    e.an = m_an; e.seg = m_seg; e.dp = 1'b1; e.pending = m_pending; e.commit = m_commit;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 16'h0);
  endtask

  // Step until the next edge is a frame-start tick (bounded)
  task automatic wait_frame_tick();
    bit found = 1'b0;
    for (int i = 0; i < 8 * D && !found; i++) begin
      if (next_is_frame_start()) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 16'h0);
    end
    if (!found) checkOutput("frame_wait", 14'd0, 14'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("cycle", {an, seg, dp, pending, commit}, e);
      end
    end
  end

  initial begin : stimulus
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0);
    idle(20);
    applyStimulus(1'b1, 1'b1, 16'h1234);
    idle(40);
    applyStimulus(1'b1, 1'b1, 16'h0050);
    idle(40);
    applyStimulus(1'b1, 1'b1, 16'h0C07);
    idle(40);
    wait_frame_tick();
    idle(1);
    applyStimulus(1'b1, 1'b1, 16'h9999);
    wait_frame_tick();
    applyStimulus(1'b1, 1'b1, 16'h1111);
    idle(40);
    applyStimulus(1'b1, 1'b1, 16'h1234);
    idle(42);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    idle(30);
    for (int i = 0; i < 600; i++) begin
      bit          r, ld;
      logic [15:0] v;
      r  = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 4; j++)
        v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      applyStimulus(r, ld, v);
    end
    idle(1);
    @(posedge clk);
    #2;
    checkOutput("drain", 14'(expq.size()), 14'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
